// File: rtl/pkt_framer_pkg.sv
// Shared definitions for the packet trailer framer.
//   DATA_W_DEF  : default payload byte width
//   MAX_LEN_DEF : default maximum payload bytes per packet before forced truncation
//   PKT_CNT_W   : width of the completed-packet counter
//   state_t     : framer FSM states
package pkt_framer_pkg;

   localparam int DATA_W_DEF  = 8;
   localparam int MAX_LEN_DEF = 64;
   localparam int PKT_CNT_W   = 16;

   typedef enum logic [1:0] {
      ST_PAYLOAD = 2'd0,
      ST_LEN     = 2'd1,
      ST_CSUM    = 2'd2
   } state_t;

endpackage

// File: rtl/pkt_framer_out_reg.sv
// Single-entry output register slice for the framer's streaming output.
// The slice is free when it is empty or its current beat is being taken this
// cycle. A load is only honoured while free; otherwise data, last and valid hold.
//   clk, reset_n : clock, async active-low reset
//   load         : write load_data/load_last into the slice (only when free)
//   load_data    : beat data to load
//   load_last    : beat last flag to load
//   m_tready     : downstream accepts the current beat
//   m_tdata      : registered output data
//   m_tvalid     : registered output valid
//   m_tlast      : registered output last
//   free         : slice can take a new beat this cycle
module pkt_framer_out_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   input  logic              m_tready,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   output logic              m_tlast,
   output logic              free
);

   assign free = !m_tvalid || m_tready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_tdata  <= '0;
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
      end else if (free) begin
         m_tvalid <= load;
         if (load) begin
            m_tdata <= load_data;
            m_tlast <= load_last;
         end
      end
   end

endmodule

// File: rtl/pkt_trailer_framer.sv
// Packet trailer framer: forwards payload bytes with one cycle of latency and
// appends a length byte and an 8-bit additive checksum byte (tlast) to every
// packet. Packets reaching MAX_LEN bytes without in_last are cut, flagged with
// a one-cycle oversize_err pulse, and the remaining bytes start a new packet.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_PAYLOAD | accepting payload bytes, accumulating len and sum
// ST_LEN     | waiting for the output slice to take the length byte
// ST_CSUM    | waiting for the output slice to take the checksum (tlast)
//
//   clk, reset_n         : clock, async active-low reset
//   in_data/valid/last   : upstream payload stream
//   in_ready             : upstream beat accepted this cycle
//   m_tdata/tvalid/tlast : framed output stream
//   m_tready             : downstream ready
//   pkt_count            : completed framed packets (wrapping)
//   oversize_err         : one-cycle pulse after a forced truncation
module pkt_trailer_framer
   import pkt_framer_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int MAX_LEN = MAX_LEN_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [DATA_W-1:0]    in_data,
   input  logic                 in_valid,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic [DATA_W-1:0]    m_tdata,
   output logic                 m_tvalid,
   output logic                 m_tlast,
   input  logic                 m_tready,
   output logic [PKT_CNT_W-1:0] pkt_count,
   output logic                 oversize_err
);

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   state_t            state;
   logic [7:0]        len;
   logic [7:0]        sum;
   logic [7:0]        len_inc;
   logic              at_max;
   logic              rdy_en;
   logic              free;
   logic              accept;
   logic              load;
   logic [DATA_W-1:0] load_data;
   logic              load_last;

   assign len_inc = len + 8'd1;
   assign at_max  = (len_inc == MAX_LEN_B);

   // rdy_en keeps in_ready low until the first clock edge after reset release
   assign in_ready = rdy_en && (state == ST_PAYLOAD) && free;
   assign accept   = in_valid && in_ready;

   always_comb begin
      load      = 1'b0;
      load_data = '0;
      load_last = 1'b0;
      case (state)
         ST_PAYLOAD: begin
            load      = accept;
            load_data = in_data;
         end
         ST_LEN: begin
            load      = free;
            load_data = DATA_W'(len);
         end
         ST_CSUM: begin
            load      = free;
            load_data = DATA_W'(sum);
            load_last = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_PAYLOAD;
         len          <= 8'd0;
         sum          <= 8'd0;
         oversize_err <= 1'b0;
         rdy_en       <= 1'b0;
      end else begin
         rdy_en       <= 1'b1;
         oversize_err <= 1'b0;
         case (state)
            ST_PAYLOAD: begin
               if (accept) begin
                  len <= len_inc;
                  sum <= sum + 8'(in_data);
                  if (in_last || at_max)
                     state <= ST_LEN;
                  // in_last on the MAX_LEN-th byte is a normal end, not a cut
                  if (at_max && !in_last)
                     oversize_err <= 1'b1;
               end
            end
            ST_LEN: begin
               if (free)
                  state <= ST_CSUM;
            end
            ST_CSUM: begin
               if (free) begin
                  len   <= 8'd0;
                  sum   <= 8'd0;
                  state <= ST_PAYLOAD;
               end
            end
            default: state <= ST_PAYLOAD;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         pkt_count <= '0;
      else if (m_tvalid && m_tready && m_tlast)
         pkt_count <= pkt_count + 1'b1;
   end

   pkt_framer_out_reg #(
      .DATA_W (DATA_W)
   ) u_out_reg (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (load),
      .load_data (load_data),
      .load_last (load_last),
      .m_tready  (m_tready),
      .m_tdata   (m_tdata),
      .m_tvalid  (m_tvalid),
      .m_tlast   (m_tlast),
      .free      (free)
   );

endmodule

// File: tb/tb_pkt_trailer_framer.sv
module tb_pkt_trailer_framer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_tlast;
   logic        m_tready;
   logic [15:0] pkt_count;
   logic        oversize_err;

   int checks   = 0;
   int failures = 0;
   int exp_pkts_total = 0;

   always #5 clk = ~clk;

   pkt_trailer_framer #(
      .DATA_W  (8),
      .MAX_LEN (64)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .m_tdata      (m_tdata),
      .m_tvalid     (m_tvalid),
      .m_tlast      (m_tlast),
      .m_tready     (m_tready),
      .pkt_count    (pkt_count),
      .oversize_err (oversize_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // One input stream of n bytes first, first+1, ... with in_last on the final byte.
   // n_a payload bytes precede the first trailer; a second packet exists when pkts==2.
   typedef struct {
      string      name;
      logic [7:0] first;
      int         n;
      bit         stall;
      int         n_a;
      logic [7:0] len_a;
      logic [7:0] sum_a;
      logic [7:0] len_b;
      logic [7:0] sum_b;
      int         pkts;
      int         errs;
   } vec_t;

   task automatic run_vec(input vec_t v);
      logic [8:0] exp_q[$];
      int         idx;
      int         got;
      int         errs;
      bit         stalled;
      bit         in_xfer;
      logic [8:0] held;

      for (int i = 0; i < v.n_a; i++) exp_q.push_back({1'b0, 8'(v.first + 8'(i))});
      exp_q.push_back({1'b0, v.len_a});
      exp_q.push_back({1'b1, v.sum_a});
      if (v.pkts == 2) begin
         for (int i = v.n_a; i < v.n; i++) exp_q.push_back({1'b0, 8'(v.first + 8'(i))});
         exp_q.push_back({1'b0, v.len_b});
         exp_q.push_back({1'b1, v.sum_b});
      end

      idx = 0; got = 0; errs = 0; stalled = 0; held = '0;
      m_tready = 1'b1;
      in_valid = 1'b1;
      in_data  = v.first;
      in_last  = (v.n == 1);

      for (int cyc = 0; cyc < 2000 && got < exp_q.size(); cyc++) begin
         @(negedge clk);
         if (stalled) begin
            check($sformatf("%s stall_valid", v.name), 32'(m_tvalid), 32'd1);
            check($sformatf("%s stall_hold", v.name), 32'({m_tlast, m_tdata}), 32'(held));
         end
         if (oversize_err) errs++;
         if (m_tvalid && m_tready) begin
            check($sformatf("%s beat%0d", v.name, got), 32'({m_tlast, m_tdata}), 32'(exp_q[got]));
            got++;
         end
         stalled = m_tvalid && !m_tready;
         held    = {m_tlast, m_tdata};
         in_xfer = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (in_xfer) idx++;
         if (v.stall) m_tready = ~m_tready;
         in_valid = (idx < v.n);
         in_data  = 8'(v.first + 8'(idx));
         in_last  = (idx == v.n - 1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      m_tready = 1'b1;

      check($sformatf("%s beat_count", v.name), 32'(got), 32'(exp_q.size()));
      check($sformatf("%s bytes_taken", v.name), 32'(idx), 32'(v.n));
      check($sformatf("%s oversize_pulses", v.name), 32'(errs), 32'(v.errs));
      exp_pkts_total += v.pkts;
      check($sformatf("%s pkt_count", v.name), 32'(pkt_count), 32'(exp_pkts_total[15:0]));
   endtask

   localparam int NV = 7;
   vec_t vecs[NV];
   vec_t post_rst;
   int   k;
   bit   xfer;

   initial begin
      vecs[0] = '{"p16",       8'h01, 16, 1'b0, 16, 8'h10, 8'h88, 8'h00, 8'h00, 1, 0};
      vecs[1] = '{"single",    8'hAB,  1, 1'b0,  1, 8'h01, 8'hAB, 8'h00, 8'h00, 1, 0};
      vecs[2] = '{"trunc70",   8'h01, 70, 1'b0, 64, 8'h40, 8'h20, 8'h06, 8'h95, 2, 1};
      vecs[3] = '{"p16_stall", 8'h01, 16, 1'b1, 16, 8'h10, 8'h88, 8'h00, 8'h00, 1, 0};
      vecs[4] = '{"exact64",   8'h01, 64, 1'b0, 64, 8'h40, 8'h20, 8'h00, 8'h00, 1, 0};
      vecs[5] = '{"wrap3",     8'hF0,  3, 1'b0,  3, 8'h03, 8'hD3, 8'h00, 8'h00, 1, 0};
      vecs[6] = '{"trunc70_st",8'h01, 70, 1'b1, 64, 8'h40, 8'h20, 8'h06, 8'h95, 2, 1};
      post_rst = '{"post_rst", 8'h01,  3, 1'b0,  3, 8'h03, 8'h06, 8'h00, 8'h00, 1, 0};

      reset_n  = 1'b0;
      in_data  = 8'h00;
      in_valid = 1'b0;
      in_last  = 1'b0;
      m_tready = 1'b1;
      #2;
      check("rst m_tvalid", 32'(m_tvalid), 32'd0);
      check("rst m_tlast", 32'(m_tlast), 32'd0);
      check("rst m_tdata", 32'(m_tdata), 32'd0);
      check("rst pkt_count", 32'(pkt_count), 32'd0);
      check("rst oversize_err", 32'(oversize_err), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst in_ready", 32'(in_ready), 32'd0);
      reset_n = 1'b1;
      #1;
      check("release in_ready_before_edge", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("release in_ready_after_edge", 32'(in_ready), 32'd1);

      for (int i = 0; i < NV; i++) run_vec(vecs[i]);

      repeat (5) begin
         @(negedge clk);
         check("idle no_extra_beat", 32'(m_tvalid), 32'd0);
      end

      // Partial packet interrupted by reset: 5 bytes without in_last
      k = 0;
      in_valid = 1'b1;
      in_data  = 8'h11;
      in_last  = 1'b0;
      for (int cyc = 0; cyc < 50 && k < 5; cyc++) begin
         @(negedge clk);
         xfer = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (xfer) k++;
         in_data = 8'(8'h11 + 8'(k));
      end
      in_valid = 1'b0;
      check("partial bytes_taken", 32'(k), 32'd5);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst m_tvalid", 32'(m_tvalid), 32'd0);
      check("midrst m_tdata", 32'(m_tdata), 32'd0);
      check("midrst m_tlast", 32'(m_tlast), 32'd0);
      check("midrst pkt_count", 32'(pkt_count), 32'd0);
      check("midrst oversize_err", 32'(oversize_err), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      exp_pkts_total = 0;
      repeat (4) begin
         @(negedge clk);
         check("midrst no_trailer", 32'(m_tvalid), 32'd0);
      end
      @(posedge clk);
      #1;
      run_vec(post_rst);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pkt_trailer_framer.md
PKT_TRAILER_FRAMER -- requirements
Module: pkt_trailer_framer

Interface
- REQ-001: Parameter DATA_W, default 8, byte width of input and output data.
- REQ-002: Parameter MAX_LEN, default 64, max payload bytes per packet (legal range 1..255).
- REQ-003: clk  input  1  single clock, all logic on rising edge.
- REQ-004: reset_n  input  1  asynchronous, active-low reset.
- REQ-005: in_data  input  DATA_W  payload byte, consumed from the upstream 2048-deep FIFO output.
- REQ-006: in_valid  input  1  in_data valid.
- REQ-007: in_last  input  1  final payload byte of packet.
- REQ-008: in_ready  output  1  block accepts the in_data beat this cycle.
- REQ-009: m_tdata  output  DATA_W  framed output byte.
- REQ-010: m_tvalid  output  1  m_tdata valid.
- REQ-011: m_tlast  output  1  final beat of framed packet (checksum byte).
- REQ-012: m_tready  input  1  downstream accepts the beat.
- REQ-013: pkt_count  output  16  completed framed packets, wraps 0xFFFF->0x0000.
- REQ-014: oversize_err  output  1  one-cycle pulse on forced truncation.

Function
- REQ-015: Beat transfers when valid && ready on a rising edge, on both ports.
- REQ-016: FSM states PAYLOAD, LEN, CSUM; PAYLOAD after reset.
- REQ-017: Single output register: "free" = !m_tvalid || m_tready.
- REQ-018: in_ready = (state==PAYLOAD) && free; combinational, no dependency on in_valid.
- REQ-019: Accepted payload byte appears on m_tdata with m_tlast=0 the next cycle (latency 1).
- REQ-020: Per-packet len (8 bit) increments, sum (8 bit, mod 256) adds in_data on every accepted payload beat.
- REQ-021: PAYLOAD->LEN on accepted beat with in_last=1 or with len+1==MAX_LEN.
- REQ-022: LEN: when free, load m_tdata=len (count incl. final byte), m_tlast=0; go CSUM.
- REQ-023: CSUM: when free, load m_tdata=sum, m_tlast=1; clear len/sum; go PAYLOAD.
- REQ-024: In LEN/CSUM in_ready=0; upstream data held, not dropped.
- REQ-025: Truncation (len+1==MAX_LEN with in_last=0): oversize_err=1 for the following cycle only; remaining bytes form a new packet.
- REQ-026: in_last on the MAX_LEN-th byte is normal termination; oversize_err stays 0.
- REQ-027: m_tvalid && !m_tready: m_tdata, m_tlast held stable, m_tvalid held high.
- REQ-028: pkt_count increments on m_tvalid && m_tready && m_tlast.
- REQ-029: Zero-length packets cannot occur; a trailer is only generated after >=1 payload byte.

Reset
- REQ-030: reset_n low: state=PAYLOAD, len=0, sum=0, m_tvalid=0, m_tlast=0, m_tdata=0, pkt_count=0, oversize_err=0, immediately (async).
- REQ-031: Reset mid-packet discards partial packet; no trailer emitted after release.
- REQ-032: First in_ready=1 no earlier than first rising edge after reset_n deasserts.

Structure
- REQ-033: Package pkt_framer_pkg holds state enum, DATA_W/MAX_LEN defaults, PKT_CNT_W=16.
- REQ-034: One sub-module pkt_framer_out_reg: output register slice (data/last/valid, load/free logic).

Verification
- REQ-035: 16-byte packet 0x01..0x10, last on 0x10, m_tready=1 -> 18 beats: 0x01..0x10, 0x10, 0x88 (tlast); pkt_count=1.
- REQ-036: Single byte 0xAB with in_last -> 0xAB, 0x01, 0xAB(tlast); no oversize_err.
- REQ-037: MAX_LEN=64, 70 bytes 0x01..0x46 last on 0x46 -> pkt A 64 bytes, 0x40, 0x20(tlast), one oversize_err pulse; pkt B 0x41..0x46, 0x06, 0x95(tlast); pkt_count=2.
- REQ-038: Same as REQ-035 with m_tready toggling 1/0 every cycle -> identical beat sequence, no loss/duplication, outputs stable while stalled.
- REQ-039: reset_n low after 5 bytes of a packet, then 3-byte packet 0x01,0x02,0x03 -> only 0x01,0x02,0x03,0x03,0x06(tlast); pkt_count=1.
- REQ-040: Exactly 64 bytes with in_last on 64th (MAX_LEN=64) -> len byte 0x40, oversize_err never asserts.
